pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder.sv | 178 +++++++++++++++++
 tb/tb_pe_feeder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// Loads filter/ifmap element buffers, streams them as pairs to a PE and captures the returned partial sum.
// Optional macro PE_FEEDER_TIMEOUT_EN bounds the wait for the partial sum; on expiry the result is 0 with err_o set.
module pe_feeder #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PSUM_W  = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic              wr_sel_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              go_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] pe_filter_o,
    output logic [DATA_W-1:0] pe_ifmap_o,
    output logic              pe_read_filter_o,
    output logic              pe_read_ifmap_o,
    output logic              pe_start_o,
    output logic              pe_end_os_o,
    input  logic [PSUM_W-1:0] pe_psum_i,
    input  logic              pe_psum_valid_i,
    output logic [PSUM_W-1:0] res_data_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              err_o
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("pe_feeder: DEPTH must be 2..16 and TIMEOUT at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_STREAM, S_END, S_WAIT, S_HOLD
    } state_t;

    state_t              r_state, w_next;
    logic [IDX_W-1:0]    r_idx, w_idx_next;
    logic [CNT_W-1:0]    r_fcnt, r_icnt;
    logic [DATA_W-1:0]   r_fbuf [DEPTH];
    logic [DATA_W-1:0]   r_ibuf [DEPTH];
    logic                r_busy, r_rd, r_start, r_end, r_res_valid;
    logic [DATA_W-1:0]   r_pe_f, r_pe_i;
    logic [PSUM_W-1:0]   r_res_data;
    logic                w_full, w_wr_f, w_wr_i, w_capture, w_timeout, w_handshake;

    assign w_full = (r_fcnt == CNT_W'(DEPTH)) && (r_icnt == CNT_W'(DEPTH));
    assign w_wr_f = (r_state == S_IDLE) && wr_en_i && !wr_sel_i && (r_fcnt != CNT_W'(DEPTH));
    assign w_wr_i = (r_state == S_IDLE) && wr_en_i &&  wr_sel_i && (r_icnt != CNT_W'(DEPTH));

`ifdef PE_FEEDER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    // Counts cycles spent in WAIT; restarts on every entry.
    always_ff @(posedge clk_i) begin
        if (rst_i || r_state != S_WAIT) r_tmo <= '0;
        else                            r_tmo <= r_tmo + TMO_W'(1);
    end
`endif

    // Next-state and per-state strobes
    always_comb begin
        w_next      = r_state;
        w_idx_next  = r_idx;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            S_IDLE:   if (go_i && w_full) w_next = S_START;
            S_START: begin
                w_next     = S_STREAM;
                w_idx_next = '0;
            end
            S_STREAM: begin
                if (r_idx == IDX_W'(DEPTH - 1)) w_next = S_END;
                else                            w_idx_next = r_idx + IDX_W'(1);
            end
            S_END:    w_next = S_WAIT;
            S_WAIT: begin
                if (pe_psum_valid_i) begin
                    w_next    = S_HOLD;
                    w_capture = 1'b1;
                end
`ifdef PE_FEEDER_TIMEOUT_EN
                else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_next    = S_HOLD;
                    w_timeout = 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (res_ready_i) begin
                    w_next      = S_IDLE;
                    w_handshake = 1'b1;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_fcnt      <= '0;
            r_icnt      <= '0;
            r_busy      <= 1'b0;
            r_rd        <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_pe_f      <= '0;
            r_pe_i      <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_busy  <= (w_next != S_IDLE);
            r_start <= (w_next == S_START);
            r_end   <= (w_next == S_END);
            r_rd    <= (w_next == S_STREAM);
            r_pe_f  <= (w_next == S_STREAM) ? r_fbuf[w_idx_next] : '0;
            r_pe_i  <= (w_next == S_STREAM) ? r_ibuf[w_idx_next] : '0;
            if (w_handshake) begin
                r_fcnt <= '0;
                r_icnt <= '0;
            end else begin
                if (w_wr_f) r_fcnt <= r_fcnt + CNT_W'(1);
                if (w_wr_i) r_icnt <= r_icnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_res_data  <= pe_psum_i;
                r_res_valid <= 1'b1;
            end else if (w_timeout) begin
                r_res_data  <= '0;
                r_res_valid <= 1'b1;
            end else if (w_handshake) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Element storage deliberately survives reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_wr_f) r_fbuf[IDX_W'(r_fcnt)] <= wr_data_i;
            if (w_wr_i) r_ibuf[IDX_W'(r_icnt)] <= wr_data_i;
        end
    end

`ifdef PE_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)            r_err <= 1'b0;
        else if (w_timeout)   r_err <= 1'b1;
        else if (w_capture || w_handshake) r_err <= 1'b0;
    end
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o           = r_busy;
    assign pe_filter_o      = r_pe_f;
    assign pe_ifmap_o       = r_pe_i;
    assign pe_read_filter_o = r_rd;
    assign pe_read_ifmap_o  = r_rd;
    assign pe_start_o       = r_start;
    assign pe_end_os_o      = r_end;
    assign res_data_o       = r_res_data;
    assign res_valid_o      = r_res_valid;

endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder: stimulus pushes expected pairs, pulse times and results; a negedge monitor pops and compares.
module tb_pe_feeder;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PSUM_W = 10;

    logic              clk = 1'b0;
    logic              rst_i, wr_en_i, wr_sel_i, go_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              busy_o, pe_read_filter_o, pe_read_ifmap_o, pe_start_o, pe_end_os_o;
    logic [DATA_W-1:0] pe_filter_o, pe_ifmap_o;
    logic [PSUM_W-1:0] pe_psum_i, res_data_o;
    logic              pe_psum_valid_i, res_valid_o, res_ready_i, err_o;

    always #5 clk = ~clk;

    pe_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PSUM_W(PSUM_W), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_data_i(wr_data_i),
        .go_i(go_i), .busy_o(busy_o), .pe_filter_o(pe_filter_o), .pe_ifmap_o(pe_ifmap_o),
        .pe_read_filter_o(pe_read_filter_o), .pe_read_ifmap_o(pe_read_ifmap_o),
        .pe_start_o(pe_start_o), .pe_end_os_o(pe_end_os_o), .pe_psum_i(pe_psum_i),
        .pe_psum_valid_i(pe_psum_valid_i), .res_data_o(res_data_o), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .err_o(err_o)
    );

    typedef struct { logic [DATA_W-1:0] f; logic [DATA_W-1:0] i; } pair_t;
    typedef struct { logic [PSUM_W-1:0] d; logic e; } res_t;

    pair_t q_pair[$];
    res_t  q_res[$];
    int    q_start[$];
    int    q_end[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: every strobe, pulse and result handshake must match the head of its queue
    always @(negedge clk) begin : mon
        pair_t p;
        res_t  r;
        int    t;
        if (mon_en) begin
            if (pe_read_filter_o || pe_read_ifmap_o) begin
                chk("rd_filter", 32'(pe_read_filter_o), 32'd1);
                chk("rd_ifmap", 32'(pe_read_ifmap_o), 32'd1);
                if (q_pair.size() == 0) fail("unexpected_stream");
                else begin
                    p = q_pair.pop_front();
                    chk("pe_filter", 32'(pe_filter_o), 32'(p.f));
                    chk("pe_ifmap", 32'(pe_ifmap_o), 32'(p.i));
                end
            end else begin
                chk("idle_filter_zero", 32'(pe_filter_o), 32'd0);
                chk("idle_ifmap_zero", 32'(pe_ifmap_o), 32'd0);
            end
            if (pe_start_o) begin
                if (q_start.size() == 0) fail("unexpected_start");
                else begin t = q_start.pop_front(); chk("start_cycle", 32'(cyc), 32'(t)); end
            end
            if (pe_end_os_o) begin
                if (q_end.size() == 0) fail("unexpected_end");
                else begin t = q_end.pop_front(); chk("end_cycle", 32'(cyc), 32'(t)); end
            end
            if (res_valid_o && res_ready_i) begin
                if (q_res.size() == 0) fail("unexpected_result");
                else begin
                    r = q_res.pop_front();
                    chk("res_data", 32'(res_data_o), 32'(r.d));
                    chk("res_err", 32'(err_o), 32'(r.e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [DATA_W-1:0] d);
        wr_en_i = 1'b1; wr_sel_i = sel; wr_data_i = d;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic load(input int f0, input int i0);
        for (int k = 0; k < int'(DEPTH); k++) wr(1'b0, DATA_W'(f0 + k));
        for (int k = 0; k < int'(DEPTH); k++) wr(1'b1, DATA_W'(i0 + k));
    endtask

    task automatic push_pairs(input int f0, input int i0, input int n);
        pair_t p;
        for (int k = 0; k < n; k++) begin
            p.f = DATA_W'(f0 + k); p.i = DATA_W'(i0 + k);
            q_pair.push_back(p);
        end
    endtask

    // go is driven at cycle n and sampled at the next edge: START at n+1, END at n+DEPTH+2
    task automatic go(input bit exp_start, input bit exp_end);
        if (exp_start) q_start.push_back(cyc + 1);
        if (exp_end)   q_end.push_back(cyc + int'(DEPTH) + 2);
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
    endtask

    task automatic wait_end();
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (pe_end_os_o) begin seen = 1'b1; break; end
        end
        chk("end_seen", 32'(seen), 32'd1);
    endtask

    // From END: step into WAIT, return a psum, then complete the handshake
    task automatic finish_txn(input logic [PSUM_W-1:0] psum, input bit early_ready);
        res_t r;
        tick();
        if (early_ready) res_ready_i = 1'b1;
        pe_psum_i = psum; pe_psum_valid_i = 1'b1;
        r.d = psum; r.e = 1'b0; q_res.push_back(r);
        tick();
        pe_psum_valid_i = 1'b0;
        chk("hold_valid", 32'(res_valid_o), 32'd1);
        if (!early_ready) begin tick(); res_ready_i = 1'b1; end
        tick();
        res_ready_i = 1'b0;
        chk("valid_dropped", 32'(res_valid_o), 32'd0);
        chk("idle_after_hs", 32'(busy_o), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_rd"}, 32'({pe_read_filter_o, pe_read_ifmap_o}), 32'd0);
        chk({tag, "_data"}, 32'({pe_filter_o, pe_ifmap_o}), 32'd0);
        chk({tag, "_pulses"}, 32'({pe_start_o, pe_end_os_o}), 32'd0);
        chk({tag, "_res"}, 32'({res_data_o, res_valid_o, err_o}), 32'd0);
    endtask

    initial begin
        res_t r;
        int   n;
        rst_i = 1'b1; wr_en_i = 1'b0; wr_sel_i = 1'b0; wr_data_i = '0; go_i = 1'b0;
        pe_psum_i = '0; pe_psum_valid_i = 1'b0; res_ready_i = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst_i = 1'b0;
        mon_en = 1'b1;

        // Basic transaction with stray psum_valid during STREAM and END, then held result
        load(1, 5);
        push_pairs(1, 5, 4);
        go(1'b1, 1'b1);
        chk("busy_after_go", 32'(busy_o), 32'd1);
        tick();
        pe_psum_i = 10'h3FF; pe_psum_valid_i = 1'b1;
        repeat (2) tick();
        pe_psum_valid_i = 1'b0;
        wait_end();
        pe_psum_valid_i = 1'b1;
        tick();
        pe_psum_i = 10'h046;
        r.d = 10'h046; r.e = 1'b0; q_res.push_back(r);
        tick();
        pe_psum_valid_i = 1'b0;
        pe_psum_i = 10'h155;
        for (int k = 0; k < 5; k++) begin
            chk("hold_stable_valid", 32'(res_valid_o), 32'd1);
            chk("hold_stable_data", 32'(res_data_o), 32'h046);
            tick();
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("valid_dropped", 32'(res_valid_o), 32'd0);
        chk("idle_after_hs", 32'(busy_o), 32'd0);

        // Partial load: go ignored, overfill write dropped, then completion works
        for (int k = 0; k < 3; k++) wr(1'b0, DATA_W'(9 + k));
        for (int k = 0; k < 4; k++) wr(1'b1, DATA_W'(12 + k));
        go(1'b0, 1'b0);
        repeat (2) tick();
        chk("go_ignored_busy", 32'(busy_o), 32'd0);
        wr(1'b1, 8'd99);
        wr(1'b0, 8'd16);
        push_pairs(9, 12, 3);
        r.d = '0; r.e = 1'b0;
        begin
            pair_t p;
            p.f = 8'd16; p.i = 8'd15;
            q_pair.push_back(p);
        end
        go(1'b1, 1'b1);
        wait_end();
        finish_txn(10'h2AB, 1'b1);

        // Reset in STREAM cycle 2 aborts the transaction
        load(20, 30);
        push_pairs(20, 30, 3);
        go(1'b1, 1'b0);
        repeat (3) tick();
        rst_i = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        rst_i = 1'b0;
        repeat (8) tick();
        chk("post_reset_idle", 32'(busy_o), 32'd0);
        load(40, 50);
        push_pairs(40, 50, 4);
        go(1'b1, 1'b1);
        wait_end();
        finish_txn(10'h155, 1'b0);

        // WAIT behaviour without a psum
        load(60, 70);
        push_pairs(60, 70, 4);
        go(1'b1, 1'b1);
        wait_end();
        tick();
        n = 0;
`ifdef PE_FEEDER_TIMEOUT_EN
        r.d = '0; r.e = 1'b1; q_res.push_back(r);
        while (!res_valid_o && n < 100) begin tick(); n++; end
        chk("timeout_cycles", 32'(n), 32'd64);
        chk("timeout_err", 32'(err_o), 32'd1);
        chk("timeout_data", 32'(res_data_o), 32'd0);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("err_cleared", 32'(err_o), 32'd0);
`else
        while (!res_valid_o && n < 80) begin tick(); n++; end
        chk("wait_indefinite", 32'(res_valid_o), 32'd0);
        chk("wait_busy", 32'(busy_o), 32'd1);
        pe_psum_i = 10'h0FF; pe_psum_valid_i = 1'b1;
        r.d = 10'h0FF; r.e = 1'b0; q_res.push_back(r);
        tick();
        pe_psum_valid_i = 1'b0;
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("late_valid_dropped", 32'(res_valid_o), 32'd0);
`endif
        repeat (2) tick();
        mon_en = 1'b0;
        chk("pairs_drained", 32'(q_pair.size()), 32'd0);
        chk("starts_drained", 32'(q_start.size()), 32'd0);
        chk("ends_drained", 32'(q_end.size()), 32'd0);
        chk("results_drained", 32'(q_res.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
